// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   A chain of DEPTH pipeline registers, each holding one
//   {valid, ctrl, mem, alu, reg} bundle. It is meant for the MEM/WB end of a
//   simple in-order pipeline. Stage 0 is the youngest stage, and stage
//   DEPTH-1 drives the out_* ports directly from its registers.
//   Update priority on each clock edge:
//     rst (asynchronous) > flush > stall > advance
//   Stall holds every stage. Flush kills every stage by clearing valid and
//   ctrl. A bubble (in_valid=0) is captured with ctrl cleared.
//   The module also does a forwarding lookup. It reports whether any in-flight
//   writer targets fwd_reg. If more than one does, the youngest one is used.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   stall, flush             hold all stages / invalidate all stages
//   in_valid/ctrl/mem/alu/reg  incoming bundle (ctrl[0]=RegWrite, ctrl[1]=MemToReg)
//   out_valid/ctrl/mem/alu/reg stage DEPTH-1 contents
//   fwd_reg                  forwarding query register index
//   fwd_hit, fwd_data        a stage will write fwd_reg, and the value it writes
//   valid_count              number of stages currently holding valid=1
module pipe_reg_chain #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 2,
    parameter int DEPTH  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_W-1:0]            in_mem,
    input  logic [DATA_W-1:0]            in_alu,
    input  logic [REG_W-1:0]             in_reg,
    output logic                         out_valid,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_W-1:0]            out_mem,
    output logic [DATA_W-1:0]            out_alu,
    output logic [REG_W-1:0]             out_reg,
    input  logic [REG_W-1:0]             fwd_reg,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data,
    output logic [$clog2(DEPTH+1)-1:0]   valid_count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    // Stage state (_q) and the value each stage takes on an advance (_d).
    logic              valid_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_q  [DEPTH];
    logic [DATA_W-1:0] mem_q   [DEPTH];
    logic [DATA_W-1:0] alu_q   [DEPTH];
    logic [REG_W-1:0]  rd_q    [DEPTH];

    logic              valid_d [DEPTH];
    logic [CTRL_W-1:0] ctrl_d  [DEPTH];
    logic [DATA_W-1:0] mem_d   [DEPTH];
    logic [DATA_W-1:0] alu_d   [DEPTH];
    logic [REG_W-1:0]  rd_d    [DEPTH];

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // A bubble keeps its data fields but must never look like a
                // writer, so its ctrl is cleared as it enters the chain.
                assign valid_d[gi] = in_valid;
                assign ctrl_d[gi]  = in_valid ? in_ctrl : '0;
                assign mem_d[gi]   = in_mem;
                assign alu_d[gi]   = in_alu;
                assign rd_d[gi]    = in_reg;
            end else begin : g_body
                assign valid_d[gi] = valid_q[gi-1];
                assign ctrl_d[gi]  = ctrl_q[gi-1];
                assign mem_d[gi]   = mem_q[gi-1];
                assign alu_d[gi]   = alu_q[gi-1];
                assign rd_d[gi]    = rd_q[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q[gi] <= 1'b0;
                    ctrl_q[gi]  <= '0;
                    mem_q[gi]   <= '0;
                    alu_q[gi]   <= '0;
                    rd_q[gi]    <= '0;
                end else if (flush) begin
                    // Only kill the instruction. The data fields are left
                    // alone because nothing reads them while valid is 0.
                    valid_q[gi] <= 1'b0;
                    ctrl_q[gi]  <= '0;
                end else if (!stall) begin
                    valid_q[gi] <= valid_d[gi];
                    ctrl_q[gi]  <= ctrl_d[gi];
                    mem_q[gi]   <= mem_d[gi];
                    alu_q[gi]   <= alu_d[gi];
                    rd_q[gi]    <= rd_d[gi];
                end
            end
        end
    endgenerate

    // Occupancy is tracked incrementally rather than by counting the valid
    // bits. On an advance, one instruction may enter and one may leave.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (!stall) begin
            cnt_d = cnt_q + CNT_W'(in_valid) - CNT_W'(valid_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Scan from the oldest stage to the youngest, so that the youngest
    // matching writer is the one whose value is kept.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_q[k] && ctrl_q[k][0] && (rd_q[k] != '0) && (rd_q[k] == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = ctrl_q[k][1] ? mem_q[k] : alu_q[k];
            end
        end
    end

    assign out_valid   = valid_q[DEPTH-1];
    assign out_ctrl    = ctrl_q[DEPTH-1];
    assign out_mem     = mem_q[DEPTH-1];
    assign out_alu     = alu_q[DEPTH-1];
    assign out_reg     = rd_q[DEPTH-1];
    assign valid_count = cnt_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Testbench for pipe_reg_chain.
//   The main instance uses DEPTH=2. A second instance with DEPTH=1 shares the
//   same inputs and is used for the single-stage scenario.
//   Expected out_* bundles are pushed to a queue when a valid input is
//   accepted. They are popped and compared when the bench's advance counter
//   says they reach the last stage.
module tb_pipe_reg_chain;

    localparam int D = 2;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_ctrl;
    logic [31:0] in_mem;
    logic [31:0] in_alu;
    logic [4:0]  in_reg;
    logic [4:0]  fwd_reg;

    logic        out_valid;
    logic [1:0]  out_ctrl;
    logic [31:0] out_mem;
    logic [31:0] out_alu;
    logic [4:0]  out_reg;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [1:0]  valid_count;

    logic        d1_out_valid;
    logic [1:0]  d1_out_ctrl;
    logic [31:0] d1_out_mem;
    logic [31:0] d1_out_alu;
    logic [4:0]  d1_out_reg;
    logic        d1_fwd_hit;
    logic [31:0] d1_fwd_data;
    logic [0:0]  d1_valid_count;

    pipe_reg_chain #(.DATA_W(32), .REG_W(5), .CTRL_W(2), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_mem(in_mem),
        .in_alu(in_alu), .in_reg(in_reg),
        .out_valid(out_valid), .out_ctrl(out_ctrl), .out_mem(out_mem),
        .out_alu(out_alu), .out_reg(out_reg),
        .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .valid_count(valid_count)
    );

    pipe_reg_chain #(.DATA_W(32), .REG_W(5), .CTRL_W(2), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_mem(in_mem),
        .in_alu(in_alu), .in_reg(in_reg),
        .out_valid(d1_out_valid), .out_ctrl(d1_out_ctrl), .out_mem(d1_out_mem),
        .out_alu(d1_out_alu), .out_reg(d1_out_reg),
        .fwd_reg(fwd_reg), .fwd_hit(d1_fwd_hit), .fwd_data(d1_fwd_data),
        .valid_count(d1_valid_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  rd;
        int          due;
    } sb_t;

    sb_t sb_q[$];
    int  adv_cnt;
    int  vec_cnt;
    int  err_cnt;
    int  cyc;

    // Expected contents of the last stage.
    logic        exp_valid;
    logic [1:0]  exp_ctrl;
    logic [31:0] exp_mem;
    logic [31:0] exp_alu;
    logic [4:0]  exp_rd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        exp_valid = 1'b0;
        exp_ctrl  = '0;
        exp_mem   = '0;
        exp_alu   = '0;
        exp_rd    = '0;
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] m,
                         input logic [31:0] a, input logic [4:0] r);
        in_valid = v;
        in_ctrl  = c;
        in_mem   = m;
        in_alu   = a;
        in_reg   = r;
    endtask

    // Take one clock edge, update the scoreboard, then check the DEPTH=2 outputs.
    task automatic step();
        sb_t         e;
        logic        hit;
        logic [31:0] dat;
        @(posedge clk);
        cyc++;
        if (flush) begin
            sb_q.delete();
            exp_valid = 1'b0;
            exp_ctrl  = '0;
        end else if (!stall) begin
            if (in_valid) begin
                e.ctrl = in_ctrl;
                e.mem  = in_mem;
                e.alu  = in_alu;
                e.rd   = in_reg;
                e.due  = adv_cnt + D;
                sb_q.push_back(e);
            end
            adv_cnt++;
            if (sb_q.size() > 0 && sb_q[0].due == adv_cnt) begin
                e = sb_q.pop_front();
                exp_valid = 1'b1;
                exp_ctrl  = e.ctrl;
                exp_mem   = e.mem;
                exp_alu   = e.alu;
                exp_rd    = e.rd;
            end else begin
                exp_valid = 1'b0;
                exp_ctrl  = '0;
            end
        end
        #1;
        check_eq("out_valid", 64'(out_valid), 64'(exp_valid));
        check_eq("out_ctrl", 64'(out_ctrl), 64'(exp_ctrl));
        if (exp_valid) begin
            check_eq("out_mem", 64'(out_mem), 64'(exp_mem));
            check_eq("out_alu", 64'(out_alu), 64'(exp_alu));
            check_eq("out_reg", 64'(out_reg), 64'(exp_rd));
        end
        check_eq("valid_count", 64'(valid_count), 64'(sb_q.size() + int'(exp_valid)));
        // Expected forwarding result: the last stage first, then stage 0
        // overrides it if stage 0 also matches.
        hit = 1'b0;
        dat = '0;
        if (exp_valid && exp_ctrl[0] && exp_rd != 0 && exp_rd == fwd_reg) begin
            hit = 1'b1;
            dat = exp_ctrl[1] ? exp_mem : exp_alu;
        end
        if (sb_q.size() > 0) begin
            if (sb_q[0].ctrl[0] && sb_q[0].rd != 0 && sb_q[0].rd == fwd_reg) begin
                hit = 1'b1;
                dat = sb_q[0].ctrl[1] ? sb_q[0].mem : sb_q[0].alu;
            end
        end
        check_eq("fwd_hit", 64'(fwd_hit), 64'(hit));
        check_eq("fwd_data", 64'(fwd_data), 64'(dat));
        $display("cyc %0d: st=%0b fl=%0b iv=%0b -> ov=%0b alu=%h cnt=%0d hit=%0b",
                 cyc, stall, flush, in_valid, out_valid, out_alu, valid_count, fwd_hit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        adv_cnt = 0;
        cyc     = 0;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; fwd_reg = '0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        model_clear();

        // Reset state, checked before any clock edge.
        #1 rst = 1'b1;
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check_eq("rst_out_mem", 64'(out_mem), 64'd0);
        check_eq("rst_out_alu", 64'(out_alu), 64'd0);
        check_eq("rst_out_reg", 64'(out_reg), 64'd0);
        check_eq("rst_valid_count", 64'(valid_count), 64'd0);
        check_eq("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        check_eq("rst_fwd_data", 64'(fwd_data), 64'd0);
        check_eq("rst_d1_out_valid", 64'(d1_out_valid), 64'd0);
        check_eq("rst_d1_valid_count", 64'(d1_valid_count), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Pass-through of one instruction, then bubbles.
        drive(1'b1, 2'b01, 32'h0, 32'h1234, 5'd5);
        step();
        check_eq("pt_cnt_e1", 64'(valid_count), 64'd1);
        check_eq("pt_ov_e1", 64'(out_valid), 64'd0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        step();
        check_eq("pt_ov_e2", 64'(out_valid), 64'd1);
        check_eq("pt_alu_e2", 64'(out_alu), 64'h1234);
        check_eq("pt_reg_e2", 64'(out_reg), 64'd5);
        check_eq("pt_cnt_e2", 64'(valid_count), 64'd1);
        step();
        check_eq("pt_cnt_e3", 64'(valid_count), 64'd0);
        check_eq("pt_ov_e3", 64'(out_valid), 64'd0);

        // Stall holds everything while new inputs are offered.
        drive(1'b1, 2'b01, 32'h0, 32'hA, 5'd1);
        step();
        drive(1'b1, 2'b01, 32'h0, 32'hB, 5'd2);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, $urandom, $urandom, 5'd3);
            step();
            check_eq("stall_alu", 64'(out_alu), 64'hA);
            check_eq("stall_cnt", 64'(valid_count), 64'd2);
        end
        stall = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        step();
        check_eq("unstall_alu", 64'(out_alu), 64'hB);

        // When flush and stall are both asserted, flush wins.
        drive(1'b1, 2'b11, 32'hC0, 32'hC, 5'd4);
        step();
        drive(1'b1, 2'b01, 32'hD0, 32'hD, 5'd6);
        step();
        flush = 1'b1;
        stall = 1'b1;
        drive(1'b1, 2'b01, 32'h0, 32'hBAD, 5'd8);
        step();
        check_eq("flush_ov", 64'(out_valid), 64'd0);
        check_eq("flush_ctrl", 64'(out_ctrl), 64'd0);
        check_eq("flush_cnt", 64'(valid_count), 64'd0);
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b1, 2'b01, 32'h0, 32'hE, 5'd9);
        step();
        check_eq("postflush_ov_e1", 64'(out_valid), 64'd0);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        step();
        check_eq("postflush_ov_e2", 64'(out_valid), 64'd1);
        check_eq("postflush_alu", 64'(out_alu), 64'hE);

        // Forwarding priority between the two stages.
        drive(1'b1, 2'b01, 32'h0, 32'h11, 5'd7);
        step();
        drive(1'b1, 2'b11, 32'h22, 32'h99, 5'd7);
        step();
        fwd_reg = 5'd7;
        #1;
        check_eq("fwd_young_hit", 64'(fwd_hit), 64'd1);
        check_eq("fwd_young_data", 64'(fwd_data), 64'h22);
        fwd_reg = 5'd0;
        #1;
        check_eq("fwd_r0_hit", 64'(fwd_hit), 64'd0);
        check_eq("fwd_r0_data", 64'(fwd_data), 64'd0);
        fwd_reg = 5'd8;
        #1;
        check_eq("fwd_miss_hit", 64'(fwd_hit), 64'd0);
        fwd_reg = 5'd0;
        drive(1'b1, 2'b01, 32'h0, 32'h11, 5'd7);
        step();
        drive(1'b1, 2'b00, 32'h22, 32'h33, 5'd7);
        step();
        fwd_reg = 5'd7;
        #1;
        check_eq("fwd_old_hit", 64'(fwd_hit), 64'd1);
        check_eq("fwd_old_data", 64'(fwd_data), 64'h11);

        // Asynchronous reset pulse between clock edges while both stages are full.
        #1 rst = 1'b1;
        #1;
        check_eq("arst_ov", 64'(out_valid), 64'd0);
        check_eq("arst_alu", 64'(out_alu), 64'd0);
        check_eq("arst_reg", 64'(out_reg), 64'd0);
        check_eq("arst_cnt", 64'(valid_count), 64'd0);
        check_eq("arst_fwd_hit", 64'(fwd_hit), 64'd0);
        check_eq("arst_fwd_data", 64'(fwd_data), 64'd0);
        #1 rst = 1'b0;
        model_clear();
        fwd_reg = 5'd0;
        drive(1'b1, 2'b01, 32'h0, 32'hF00D, 5'd3);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        step();
        check_eq("postrst_alu", 64'(out_alu), 64'hF00D);

        // Single-stage instance.
        drive(1'b1, 2'b11, 32'hDEAD, 32'h5, 5'd9);
        fwd_reg = 5'd9;
        step();
        check_eq("d1_out_valid", 64'(d1_out_valid), 64'd1);
        check_eq("d1_out_mem", 64'(d1_out_mem), 64'hDEAD);
        check_eq("d1_cnt", 64'(d1_valid_count), 64'd1);
        check_eq("d1_fwd_hit", 64'(d1_fwd_hit), 64'd1);
        check_eq("d1_fwd_data", 64'(d1_fwd_data), 64'hDEAD);

        // Random traffic, checked through the scoreboard.
        for (int i = 0; i < 300; i++) begin
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            fwd_reg = 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  5'($urandom_range(0, 7)));
            step();
        end
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 3; i++) step();
        check_eq("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
